micro_ctrl_fsm: RTL and testbench
=================================

Name: micro_ctrl_fsm

Overview:
- Parametrised multi-cycle control unit for the 8-bit micro datapath.
- Sequences the instruction cycle IDLE -> FETCH -> EXEC -> FETCH and decodes the opcode into datapath strobes: IR, PC, register, accumulator and ALU selects.
- Adds behaviour beyond the base controller: memory-ready wait states in FETCH, a HALT state with resume, illegal-opcode flagging, and a saturating retired-instruction counter.
- Sits between the instruction register and the datapath muxes.

Parameters:
- OPW, 4, opcode width; must be >= 4; bits above [3:0] must be zero for a legal opcode.
- ALUW, 4, SelALU width; must be >= 4; ALU codes below are zero-extended.
- CNTW, 16, width of the retired-instruction counter.
- FETCH_ALU, 4'b0010, SelALU value driven while in FETCH.

Ports:
- CLK, in, 1, clock; all state changes on the rising edge.
- CLB, in, 1, reset; synchronous, active-low.
- Opcode, in, OPW, current instruction opcode from the IR.
- Z, in, 1, zero flag.
- C, in, 1, carry flag.
- MemRdy, in, 1, instruction memory data valid.
- Resume, in, 1, leave HALT.
- LoadIR, out, 1, load the instruction register.
- IncPC, out, 1, PC <= PC + 1.
- SelPC, out, 1, PC source: 1 = register, 0 = immediate.
- LoadPC, out, 1, load PC from the SelPC source.
- LoadReg, out, 1, write the register file from the accumulator.
- LoadAcc, out, 1, load the accumulator.
- SelAcc, out, 2, accumulator source: 00 = ALU, 01 = register, 10 = immediate.
- SelALU, out, ALUW, ALU operation select.
- Halted, out, 1, high while in HALT.
- IllegalOp, out, 1, one-cycle pulse on an illegal opcode.
- InstrCount, out, CNTW, retired instructions.
- State, out, 2, current state: IDLE = 00, FETCH = 01, EXEC = 10, HALT = 11.

Behaviour:
- Reset: CLB is sampled on the rising edge of CLK. CLB = 0 forces state IDLE and InstrCount = 0. Reset overrides every other input in every state, including mid-FETCH wait and HALT.
- Output timing: all strobes decode combinationally from the registered state, Opcode, Z and C. Any strobe not listed for a state or opcode is 0.
- IDLE:
  - All outputs 0 (Halted = 0, IllegalOp = 0).
  - Next state is FETCH unconditionally.
- FETCH:
  - SelALU = FETCH_ALU.
  - LoadIR = MemRdy.
  - MemRdy = 0: stay in FETCH. The number of wait cycles is unbounded.
  - MemRdy = 1: go to EXEC.
- EXEC: exactly one cycle. Opcode is decoded as below.
  - 0000 NOP: IncPC.
  - 0001 ADD: SelALU = 1000, LoadAcc, IncPC.
  - 0010 SUB: SelALU = 1100, LoadAcc, IncPC.
  - 0011 NOR: SelALU = 0100, LoadAcc, IncPC.
  - 0100 MOVA: SelAcc = 01, LoadAcc, IncPC.
  - 0101 MOVR: LoadReg, IncPC.
  - 0110 JZR: if Z, LoadPC and SelPC = 1; else IncPC.
  - 0111 JZI: if Z, LoadPC and SelPC = 0; else IncPC.
  - 1000 JCR: if C, LoadPC and SelPC = 1; else IncPC.
  - 1010 JCI: if C, LoadPC and SelPC = 0; else IncPC.
  - 1011 SHL: SelALU = 0001, LoadAcc, IncPC.
  - 1100 SHR: SelALU = 0011, LoadAcc, IncPC.
  - 1101 LDI: SelAcc = 10, LoadAcc, IncPC.
  - 1111 HALT: IncPC, then next state is HALT.
  - 1001, 1110, or any nonzero bit above bit 3: illegal. Treated as NOP and IllegalOp = 1 for this cycle.
  - A branch that is not taken always asserts IncPC. LoadPC and IncPC are never both 1.
  - Next state is FETCH, except after HALT.
  - InstrCount increments by 1 on leaving EXEC for every opcode, including illegal opcodes and HALT. It saturates at all-ones.
- HALT:
  - All strobes 0; Halted = 1.
  - Resume = 1: go to FETCH. The PC was already advanced by the HALT instruction.
  - Resume = 0: stay in HALT.
  - Resume is ignored in every other state.
- Flags: Z and C are sampled only in EXEC. Changes on Z or C in FETCH, HALT or IDLE have no effect.
- Throughput: 2 cycles per instruction with no wait states. Each cycle of MemRdy = 0 in FETCH adds 1 cycle.

Test Plan:
- Reset: CLB = 0 for 2 cycles in any state, then 1 -> State = 00 for one cycle, then 01. All strobes 0 and InstrCount = 0 during reset.
- ADD with wait states: MemRdy = 0 for 3 cycles then 1, Opcode = 0001.
  - FETCH lasts 4 cycles with SelALU = 0010.
  - LoadIR = 1 only in the 4th FETCH cycle.
  - In EXEC: SelALU = 1000, LoadAcc = 1, IncPC = 1.
  - InstrCount goes 0 -> 1.
- JZI not taken / taken: Opcode = 0111.
  - Z = 0 -> IncPC = 1, LoadPC = 0.
  - Z = 1 -> LoadPC = 1, SelPC = 0, IncPC = 0.
  - Repeat with opcode 1000 and C = 1 -> LoadPC = 1, SelPC = 1.
- HALT then resume: Opcode = 1111.
  - EXEC gives IncPC = 1, then State = 11 and Halted = 1.
  - Hold Resume = 0 for 5 cycles -> state unchanged, all strobes 0.
  - Resume = 1 -> FETCH on the next cycle.
- Illegal opcode: Opcode 1001, 1110, and (with OPW = 5) 10001 -> IllegalOp = 1 for the EXEC cycle only, IncPC = 1, LoadAcc = 0, LoadReg = 0, LoadPC = 0.
- Counter saturation and reset mid-operation:
  - With CNTW = 3, run 9 NOPs -> InstrCount stops at 7.
  - Assert CLB = 0 during EXEC -> next state IDLE, InstrCount = 0.

Source files
------------

// File: rtl/micro_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : micro_ctrl_fsm
// Description : Multi-cycle controller for the 8-bit micro datapath, with fetch
//               wait states, HALT/resume, illegal-opcode flag and retired count.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_ctrl_fsm #(
    parameter int         OPW       = 4,
    parameter int         ALUW      = 4,
    parameter int         CNTW      = 16,
    parameter logic [3:0] FETCH_ALU = 4'b0010
) (
    input  logic            CLK,
    input  logic            CLB,
    input  logic [OPW-1:0]  Opcode,
    input  logic            Z,
    input  logic            C,
    input  logic            MemRdy,
    input  logic            Resume,
    output logic            LoadIR,
    output logic            IncPC,
    output logic            SelPC,
    output logic            LoadPC,
    output logic            LoadReg,
    output logic            LoadAcc,
    output logic [1:0]      SelAcc,
    output logic [ALUW-1:0] SelALU,
    output logic            Halted,
    output logic            IllegalOp,
    output logic [CNTW-1:0] InstrCount,
    output logic [1:0]      State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_count;
    logic [3:0]      w_op;
    logic            w_hi_nz;
    logic            w_illegal;
    logic [3:0]      w_alu4;

    assign w_op = Opcode[3:0];

    generate
        if (OPW > 4) begin : g_wide_op
            assign w_hi_nz = |Opcode[OPW-1:4];
        end else begin : g_narrow_op
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    assign w_illegal = w_hi_nz || (w_op == 4'b1001) || (w_op == 4'b1110);

    always_ff @(posedge CLK) begin
        if (!CLB) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: if (MemRdy) r_state <= S_EXEC;
                S_EXEC: begin
                    // Every instruction retires here, illegal and HALT included
                    if (r_count != {CNTW{1'b1}})
                        r_count <= r_count + CNTW'(1);
                    r_state <= (!w_hi_nz && w_op == 4'b1111) ? S_HALT : S_FETCH;
                end
                S_HALT:  if (Resume) r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        LoadIR    = 1'b0;
        IncPC     = 1'b0;
        SelPC     = 1'b0;
        LoadPC    = 1'b0;
        LoadReg   = 1'b0;
        LoadAcc   = 1'b0;
        SelAcc    = 2'b00;
        w_alu4    = 4'b0000;
        Halted    = 1'b0;
        IllegalOp = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu4 = FETCH_ALU;
                LoadIR = MemRdy;
            end
            S_HALT: Halted = 1'b1;
            S_EXEC: begin
                if (w_illegal) begin
                    IllegalOp = 1'b1;
                    IncPC     = 1'b1;
                end else begin
                    case (w_op)
                        4'b0001: begin w_alu4 = 4'b1000; LoadAcc = 1'b1; IncPC = 1'b1; end
                        4'b0010: begin w_alu4 = 4'b1100; LoadAcc = 1'b1; IncPC = 1'b1; end
                        4'b0011: begin w_alu4 = 4'b0100; LoadAcc = 1'b1; IncPC = 1'b1; end
                        4'b0100: begin SelAcc = 2'b01;   LoadAcc = 1'b1; IncPC = 1'b1; end
                        4'b0101: begin LoadReg = 1'b1; IncPC = 1'b1; end
                        4'b0110: begin LoadPC = Z; SelPC = Z;    IncPC = ~Z; end
                        4'b0111: begin LoadPC = Z; SelPC = 1'b0; IncPC = ~Z; end
                        4'b1000: begin LoadPC = C; SelPC = C;    IncPC = ~C; end
                        4'b1010: begin LoadPC = C; SelPC = 1'b0; IncPC = ~C; end
                        4'b1011: begin w_alu4 = 4'b0001; LoadAcc = 1'b1; IncPC = 1'b1; end
                        4'b1100: begin w_alu4 = 4'b0011; LoadAcc = 1'b1; IncPC = 1'b1; end
                        4'b1101: begin SelAcc = 2'b10;   LoadAcc = 1'b1; IncPC = 1'b1; end
                        default: IncPC = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign SelALU     = ALUW'(w_alu4);
    assign InstrCount = r_count;
    assign State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_micro_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_ctrl_fsm
// Description : Directed plus random stimulus against an opcode-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_ctrl_fsm;

    localparam int         OPW  = 5;
    localparam int         ALUW = 4;
    localparam int         CNTW = 3;
    localparam int         CMAX = (1 << CNTW) - 1;
    localparam logic [3:0] FALU = 4'b0010;

    logic            CLK = 1'b0;
    logic            CLB = 1'b0;
    logic [OPW-1:0]  Opcode = '0;
    logic            Z = 1'b0, C = 1'b0, MemRdy = 1'b0, Resume = 1'b0;
    logic            LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, Halted, IllegalOp;
    logic [1:0]      SelAcc, State;
    logic [ALUW-1:0] SelALU;
    logic [CNTW-1:0] InstrCount;

    micro_ctrl_fsm #(.OPW(OPW), .ALUW(ALUW), .CNTW(CNTW), .FETCH_ALU(FALU)) dut (
        .CLK(CLK), .CLB(CLB), .Opcode(Opcode), .Z(Z), .C(C), .MemRdy(MemRdy),
        .Resume(Resume), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
        .SelALU(SelALU), .Halted(Halted), .IllegalOp(IllegalOp),
        .InstrCount(InstrCount), .State(State)
    );

    always #5 CLK = ~CLK;

    logic [18:0] obs;
    assign obs = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
                  Halted, IllegalOp, InstrCount, State};

    int passed = 0;
    int total  = 0;
    int m_state = 0;   // 0 idle, 1 fetch, 2 exec, 3 halt
    int m_cnt   = 0;

    function automatic logic [18:0] model_outs(int st, int cnt, int op, bit z, bit c, bit mr);
        logic ldir = 0, inc = 0, selpc = 0, ldpc = 0, ldreg = 0, ldacc = 0, halt = 0, ill = 0;
        logic [1:0] sacc = 0;
        logic [3:0] alu = 0;
        bit taken;
        if (st == 1) begin
            alu  = FALU;
            ldir = mr;
        end else if (st == 3) begin
            halt = 1;
        end else if (st == 2) begin
            if (op > 15 || op == 9 || op == 14) begin
                ill = 1;
                inc = 1;
            end else begin
                case (op)
                    1:  begin alu = 4'b1000; ldacc = 1; inc = 1; end
                    2:  begin alu = 4'b1100; ldacc = 1; inc = 1; end
                    3:  begin alu = 4'b0100; ldacc = 1; inc = 1; end
                    11: begin alu = 4'b0001; ldacc = 1; inc = 1; end
                    12: begin alu = 4'b0011; ldacc = 1; inc = 1; end
                    4:  begin sacc = 2'b01; ldacc = 1; inc = 1; end
                    13: begin sacc = 2'b10; ldacc = 1; inc = 1; end
                    5:  begin ldreg = 1; inc = 1; end
                    6, 7, 8, 10: begin
                        taken = (op < 8) ? z : c;
                        if (taken) begin
                            ldpc  = 1;
                            selpc = (op == 6 || op == 8);
                        end else begin
                            inc = 1;
                        end
                    end
                    default: inc = 1;
                endcase
            end
        end
        return {ldir, inc, selpc, ldpc, ldreg, ldacc, sacc, alu, halt, ill,
                3'(cnt), 2'(st)};
    endfunction

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    // One clock: drive, compare before the edge, then advance the model
    task automatic step(bit clb, int op, bit z, bit c, bit mr, bit res, bit chk, string tag);
        @(negedge CLK);
        CLB = clb; Opcode = OPW'(op); Z = z; C = c; MemRdy = mr; Resume = res;
        #1;
        if (chk) check(tag, 32'(obs), 32'(model_outs(m_state, m_cnt, op, z, c, mr)));
        @(posedge CLK);
        if (!clb) begin
            m_state = 0;
            m_cnt   = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (mr) m_state = 2;
                2: begin
                    if (m_cnt < CMAX) m_cnt++;
                    m_state = (op == 15) ? 3 : 1;
                end
                default: if (res) m_state = 1;
            endcase
        end
    endtask

    task automatic instr(int op, bit z, bit c, string tag);
        step(1, op, $urandom_range(0, 1), $urandom_range(0, 1), 1, 0, 1, "fetch");
        step(1, op, z, c, $urandom_range(0, 1), $urandom_range(0, 1), 1, tag);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, "rst0");
        step(0, 0, 0, 0, 1, 1, 1, "rst1");
        step(1, 0, 1, 1, 1, 1, 1, "idle");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1, 1, "fetch_wait");
        step(1, 1, 0, 0, 1, 0, 1, "fetch_rdy");
        step(1, 1, 0, 0, 0, 0, 1, "exec_add");
        instr(7, 0, 1, "jzi_not_taken");
        instr(7, 1, 0, "jzi_taken");
        instr(8, 0, 1, "jcr_taken");
        instr(10, 1, 0, "jci_not_taken");
        instr(15, 0, 0, "exec_halt");
        for (int i = 0; i < 5; i++)
            step(1, $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), 0, 1, "halt_hold");
        step(1, 0, 0, 0, 0, 1, 1, "halt_resume");
        step(1, 0, 0, 0, 0, 0, 1, "after_resume");
        instr(9, 0, 0, "illegal_1001");
        instr(14, 0, 0, "illegal_1110");
        instr(17, 1, 1, "illegal_10001");
        step(0, 0, 0, 0, 0, 0, 1, "rst_mid");
        step(1, 0, 0, 0, 0, 0, 1, "idle2");
        for (int i = 0; i < 9; i++) instr(0, 0, 0, "nop");
        #1;
        check("sat_count", 32'(InstrCount), 32'(CMAX));
        step(1, 2, 0, 0, 1, 0, 1, "fetch_sub");
        step(0, 2, 0, 0, 0, 0, 1, "exec_rst");
        step(1, 0, 0, 0, 0, 0, 1, "idle_after_rst");
        for (int i = 0; i < 400; i++) begin
            int op;
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 15);
            step($urandom_range(0, 24) != 0, op, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1), 1, "random");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
